// File: rtl/rp_8bit_bd_arb.sv
// Two-master arbiter for the single-ported data memory (bd bus).
// Round-robin grant, one-cycle registered acknowledge, m1 bus lock with timeout.
module rp_8bit_bd_arb #(
  parameter int unsigned DAW = 13,
  parameter int unsigned DW  = 8,
  parameter int unsigned LTO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req,
  input  logic           m0_wen,
  input  logic [DAW-1:0] m0_adr,
  input  logic [DW-1:0]  m0_wdt,
  output logic [DW-1:0]  m0_rdt,
  output logic           m0_ack,
  input  logic           m1_req,
  input  logic           m1_wen,
  input  logic           m1_lck,
  input  logic [DAW-1:0] m1_adr,
  input  logic [DW-1:0]  m1_wdt,
  output logic [DW-1:0]  m1_rdt,
  output logic           m1_ack,
  output logic           mem_ena,
  output logic           mem_wen,
  output logic [DAW-1:0] mem_adr,
  output logic [DW-1:0]  mem_wdt,
  input  logic [DW-1:0]  mem_rdt,
  output logic           lck_err
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(LTO - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LTO);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lg_q, lg_d;          // last grant: 0 = m0, 1 = m1
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic          lck_err_q, lck_err_d;

  logic          elig0, elig1;
  logic          gnt0, gnt1;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_UNLOCKED;
      cnt_q     <= '0;
      lg_q      <= 1'b1;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      lck_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lg_q      <= lg_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      lck_err_q <= lck_err_d;
    end
  end

  // Next-state: lock FSM, timeout counter, round-robin pointer, acks
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lck_err_d = lck_err_q;
    m0_ack_d  = gnt0;
    m1_ack_d  = gnt1;
    if (gnt1) begin
      lg_d = 1'b1;
    end else if (gnt0) begin
      lg_d = 1'b0;
    end else begin
      lg_d = lg_q;
    end

    case (state_q)
      ST_UNLOCKED: begin
        if (gnt1 && m1_lck) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (gnt1 && !m1_lck) begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // Timeout: force the lock off and hand the next tie to m0
          state_d   = ST_UNLOCKED;
          cnt_d     = '0;
          lck_err_d = 1'b1;
          lg_d      = 1'b1;
        end else if (cnt_q >= CNT_MAX) begin
          cnt_d = CNT_MAX;
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: eligibility, combinational grant and memory mux
  always_comb begin
    elig0 = m0_req & ~m0_ack_q & (state_q == ST_UNLOCKED);
    elig1 = m1_req & ~m1_ack_q;
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (elig0 && elig1) begin
      if (lg_q) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (elig0) begin
      gnt0 = 1'b1;
    end else if (elig1) begin
      gnt1 = 1'b1;
    end

    mem_ena = gnt0 | gnt1;
    mem_wen = 1'b0;
    mem_adr = '0;
    mem_wdt = '0;
    if (gnt0) begin
      mem_wen = m0_wen;
      mem_adr = m0_adr;
      mem_wdt = m0_wdt;
    end else if (gnt1) begin
      mem_wen = m1_wen;
      mem_adr = m1_adr;
      mem_wdt = m1_wdt;
    end

    m0_ack  = m0_ack_q;
    m1_ack  = m1_ack_q;
    lck_err = lck_err_q;
    m0_rdt  = m0_ack_q ? mem_rdt : '0;
    m1_rdt  = m1_ack_q ? mem_rdt : '0;
  end

endmodule
